// File: rtl/pulse_pkg.sv
// pulse_pkg: definitions shared by the pulse sequencer, its sub-module and
// the UART pulse-control block.
//   phase_t            : shot phase encoding (also exposed as a debug output)
//   CYCLE_NS           : fabric clock period in ns (201 MHz)
//   DEF_*              : reset timings, so that the control block and the
//                        sequencer come out of reset with identical values
//   first_phase()      : first non-skipped phase of a shot
//   after_p1/after_del : phase entered when P1/DEL ends, with zero-length
//                        phases skipped
//   is_pulse()         : ungated RF gate condition for a phase
`timescale 1ns/1ps
package pulse_pkg;

    typedef enum logic [2:0] {
        PH_P1   = 3'd0,
        PH_DEL  = 3'd1,
        PH_P2   = 3'd2,
        PH_GAP  = 3'd3,
        PH_TAIL = 3'd4
    } phase_t;

    localparam real CYCLE_NS = 4.975;

    localparam logic [31:0] DEF_PER = 32'd10000;
    localparam logic [15:0] DEF_P1W = 16'd40;
    localparam logic [15:0] DEF_DEL = 16'd150;
    localparam logic [15:0] DEF_P2W = 16'd200;
    localparam logic [7:0]  DEF_PBL = 8'd100;

    // A zero-width pulse 2 produces nothing to repeat, so the shot idles in
    // TAIL rather than cycling through an empty CPMG train.
    function automatic phase_t after_del(input logic [15:0] p2w);
        return (p2w != 16'd0) ? PH_P2 : PH_TAIL;
    endfunction

    function automatic phase_t after_p1(input logic [15:0] dl, input logic [15:0] p2w);
        return (dl != 16'd0) ? PH_DEL : after_del(p2w);
    endfunction

    function automatic phase_t first_phase(input logic [15:0] p1w, input logic [15:0] dl,
                                           input logic [15:0] p2w);
        return (p1w != 16'd0) ? PH_P1 : after_p1(dl, p2w);
    endfunction

    function automatic logic is_pulse(input phase_t ph);
        return (ph == PH_P1) || (ph == PH_P2);
    endfunction

endpackage

// File: rtl/inhibit_stretch.sv
// inhibit_stretch: receiver-inhibit generator. The output is high while the
// ungated pulse condition holds and for `tail` cycles after each of its
// falling edges (the tail counter reloads on every fall).
//   clk, rst_n : fabric clock, asynchronous active-low reset
//   lvl_nxt    : ungated pulse condition for the upcoming cycle
//   tail       : number of stretch cycles after a fall (0 = no stretch)
//   inhib      : registered inhibit, aligned with the cycle lvl_nxt describes
`timescale 1ns/1ps
module inhibit_stretch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lvl_nxt,
    input  logic [7:0] tail,
    output logic       inhib
);

    logic       lvl_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_nxt;

    // cnt_q = tail cycles still owed, counting the current cycle.
    always_comb begin
        cnt_nxt = cnt_q;
        if (lvl_q && !lvl_nxt) begin
            cnt_nxt = tail;
        end else if (cnt_q != 8'd0) begin
            cnt_nxt = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
            cnt_q <= 8'd0;
            inhib <= 1'b0;
        end else begin
            lvl_q <= lvl_nxt;
            cnt_q <= cnt_nxt;
            inhib <= lvl_nxt | (cnt_nxt != 8'd0);
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: per-shot RF gate / receiver-inhibit / scope-sync generator
// for single-echo and CPMG sequences, with double-buffered timing registers.
//   clk, rst_n          : fabric clock, asynchronous active-low reset
//   per,p1wid,del,p2wid : period, pulse-1 width, delay, pulse-2 width (cycles)
//   cp, p_bl            : CPMG select, inhibit tail length
//   bl                  : live pulse enable (not shadowed)
//   rxd                 : commit strobe from the control block
//   pulse, inhib, sync  : registered waveforms, cycle-exact to shot time t
//   busy_upd            : an update is pending and not yet applied
//   phase_dbg           : current phase, for debug/checkers
//
// Update protocol: a rising edge of rxd marks the input ports as the new
// parameter set and raises busy_upd. The set is copied into the shadows on
// the last cycle of the running shot, so the next shot starts with it and
// busy_upd drops in that shot's first cycle. Inputs must stay stable while
// busy_upd is high.
`timescale 1ns/1ps
module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int SYNC_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic        cp,
    input  logic [7:0]  p_bl,
    input  logic        bl,
    input  logic        rxd,
    output logic        pulse,
    output logic        inhib,
    output logic        sync,
    output logic        busy_upd,
    output phase_t      phase_dbg
);

    localparam logic [31:0] SYNC_LEN = 32'(SYNC_W);

    // run_q is low only until the first edge after reset; that edge begins t=0.
    logic        run_q;
    logic [31:0] t_q, t_nxt;
    phase_t      phase_q, phase_nxt;
    logic [16:0] pc_q, pc_nxt;

    logic [31:0] per_sh, per_nx;
    logic [15:0] p1w_sh, p1w_nx, del_sh, del_nx, p2w_sh, p2w_nx;
    logic        cp_sh, cp_nx;
    logic [7:0]  pbl_sh, pbl_nx;

    logic        rxd_q, pend_q, pend_nxt;
    logic [31:0] per_s;
    logic        wrap, apply;
    logic [16:0] len;
    logic        done;
    logic        pulse_nxt;

    always_comb begin
        per_s    = (per_sh < 32'd2) ? 32'd2 : per_sh;
        wrap     = run_q && (t_q == per_s - 32'd1);
        apply    = wrap && pend_q;
        // A rise on the wrap cycle itself survives the clear and waits a shot.
        pend_nxt = (rxd && !rxd_q) || (pend_q && !apply);

        per_nx = apply ? per   : per_sh;
        p1w_nx = apply ? p1wid : p1w_sh;
        del_nx = apply ? del   : del_sh;
        p2w_nx = apply ? p2wid : p2w_sh;
        cp_nx  = apply ? cp    : cp_sh;
        pbl_nx = apply ? p_bl  : pbl_sh;

        case (phase_q)
            PH_P1:   len = {1'b0, p1w_sh};
            PH_DEL:  len = {1'b0, del_sh};
            PH_P2:   len = {1'b0, p2w_sh};
            PH_GAP:  len = {del_sh, 1'b0};
            default: len = 17'd0;
        endcase
        done = (pc_q + 17'd1) >= len;

        t_nxt     = t_q + 32'd1;
        phase_nxt = phase_q;
        pc_nxt    = pc_q + 17'd1;
        if (!run_q || wrap) begin
            // The new shot already sees any shadows applied on this wrap.
            t_nxt     = 32'd0;
            phase_nxt = first_phase(p1w_nx, del_nx, p2w_nx);
            pc_nxt    = 17'd0;
        end else if (phase_q == PH_TAIL) begin
            pc_nxt = pc_q;
        end else if (done) begin
            pc_nxt = 17'd0;
            case (phase_q)
                PH_P1:   phase_nxt = after_p1(del_sh, p2w_sh);
                PH_DEL:  phase_nxt = after_del(p2w_sh);
                // With no delay the CPMG gap is empty and P2 simply restarts.
                PH_P2:   phase_nxt = cp_sh ? ((del_sh != 16'd0) ? PH_GAP : PH_P2) : PH_TAIL;
                PH_GAP:  phase_nxt = PH_P2;
                default: phase_nxt = PH_TAIL;
            endcase
        end

        pulse_nxt = is_pulse(phase_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            t_q     <= 32'd0;
            phase_q <= PH_P1;
            pc_q    <= 17'd0;
            per_sh  <= DEF_PER;
            p1w_sh  <= DEF_P1W;
            del_sh  <= DEF_DEL;
            p2w_sh  <= DEF_P2W;
            cp_sh   <= 1'b0;
            pbl_sh  <= DEF_PBL;
            rxd_q   <= 1'b0;
            pend_q  <= 1'b0;
            pulse   <= 1'b0;
            sync    <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            t_q     <= t_nxt;
            phase_q <= phase_nxt;
            pc_q    <= pc_nxt;
            per_sh  <= per_nx;
            p1w_sh  <= p1w_nx;
            del_sh  <= del_nx;
            p2w_sh  <= p2w_nx;
            cp_sh   <= cp_nx;
            pbl_sh  <= pbl_nx;
            rxd_q   <= rxd;
            pend_q  <= pend_nxt;
            pulse   <= bl & pulse_nxt;
            sync    <= (t_nxt < SYNC_LEN);
        end
    end

    // Tail length comes from the shadow in force for the cycle being left.
    inhibit_stretch u_inhibit_stretch (
        .clk     (clk),
        .rst_n   (rst_n),
        .lvl_nxt (pulse_nxt),
        .tail    (pbl_sh),
        .inhib   (inhib)
    );

    assign busy_upd  = pend_q;
    assign phase_dbg = phase_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: directed bench for pulse_sequencer. Outputs are sampled
// on the falling clock edge, where the sample taken after the edge that starts
// shot cycle t shows the waveforms of cycle t.
`timescale 1ns/1ps
module tb_pulse_sequencer;
    import pulse_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid;
    logic        cp;
    logic [7:0]  p_bl;
    logic        bl;
    logic        rxd;
    logic        pulse, inhib, sync, busy_upd;
    phase_t      phase_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    always #(CYCLE_NS / 2.0) clk = ~clk;

    pulse_sequencer #(.SYNC_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .per       (per),
        .p1wid     (p1wid),
        .del       (del),
        .p2wid     (p2wid),
        .cp        (cp),
        .p_bl      (p_bl),
        .bl        (bl),
        .rxd       (rxd),
        .pulse     (pulse),
        .inhib     (inhib),
        .sync      (sync),
        .busy_upd  (busy_upd),
        .phase_dbg (phase_dbg)
    );

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic set_inputs(input logic [31:0] a_per, input logic [15:0] a_p1,
                              input logic [15:0] a_del, input logic [15:0] a_p2,
                              input logic a_cp, input logic [7:0] a_pbl);
        per   = a_per;
        p1wid = a_p1;
        del   = a_del;
        p2wid = a_p2;
        cp    = a_cp;
        p_bl  = a_pbl;
    endtask

    // Advances until sync rises; the sample where it does is t=0 of a shot.
    task automatic wait_sync_rise(input string tag, input int bound);
        logic prev;
        bit   found;
        prev  = sync;
        found = 0;
        for (int i = 0; i < bound; i++) begin
            next_cycle();
            if (sync && !prev) begin
                found = 1;
                break;
            end
            prev = sync;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s: sync rise seen=%0d, required=1 within %0d cycles", tag, found, bound);
        end
    endtask

    // Cycles from the current sample to the next sync rise (-1 if none).
    task automatic count_to_sync_rise(input int bound, output int n);
        logic prev;
        prev = sync;
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            next_cycle();
            if (sync && !prev) begin
                n = i;
                break;
            end
            prev = sync;
        end
    endtask

    // Pulses rxd for one cycle and returns at t=0 of the shot using the new set.
    task automatic commit(input string tag);
        bit cleared;
        rxd = 1'b1;
        next_cycle();
        rxd = 1'b0;
        n_cmp++;
        if (busy_upd !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy_set: busy_upd=%b, required=1", tag, busy_upd);
        end
        cleared = 0;
        for (int i = 0; i < 21000; i++) begin
            next_cycle();
            if (busy_upd === 1'b0) begin
                cleared = 1;
                break;
            end
        end
        n_cmp++;
        if (!cleared) begin
            n_bad++;
            $display("FAIL %s_apply: busy_upd cleared=%0d, required=1", tag, cleared);
        end
    endtask

    // Default-timing shot, t=0..599, starting at the t=0 sample.
    task automatic check_default_window(input string tag, input logic exp_bl);
        logic exp_p, exp_i, exp_s;
        for (int t = 0; t < 600; t++) begin
            if (t > 0) next_cycle();
            exp_p = exp_bl & ((t < 40) || (t >= 190 && t < 390));
            exp_i = (t < 140) || (t >= 190 && t < 490);
            exp_s = (t < 4);
            n_cmp++;
            if (pulse !== exp_p) begin
                n_bad++;
                $display("FAIL %s_pulse t=%0d: got %b, required %b", tag, t, pulse, exp_p);
            end
            n_cmp++;
            if (inhib !== exp_i) begin
                n_bad++;
                $display("FAIL %s_inhib t=%0d: got %b, required %b", tag, t, inhib, exp_i);
            end
            n_cmp++;
            if (sync !== exp_s) begin
                n_bad++;
                $display("FAIL %s_sync t=%0d: got %b, required %b", tag, t, sync, exp_s);
            end
            if (t == 100 || t == 400) begin
                n_cmp++;
                if (phase_dbg !== ((t == 100) ? PH_DEL : PH_TAIL)) begin
                    n_bad++;
                    $display("FAIL %s_phase t=%0d: got %0d", tag, t, phase_dbg);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_inputs(DEF_PER, DEF_P1W, DEF_DEL, DEF_P2W, 1'b0, DEF_PBL);
        bl    = 1'b1;
        rxd   = 1'b0;
        rst_n = 1'b0;
        skip(3);
        n_cmp++;
        if ({pulse, inhib, sync, busy_upd} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b%b%b%b, required 0000", pulse, inhib, sync, busy_upd);
        end
        n_cmp++;
        if (phase_dbg !== PH_P1) begin
            n_bad++;
            $display("FAIL reset_phase: got %0d, required %0d", phase_dbg, PH_P1);
        end
    endtask

    task automatic test_defaults();
        int n;
        rst_n = 1'b1;
        wait_sync_rise("first_shot", 10);
        check_default_window("defaults", 1'b1);
        count_to_sync_rise(20000, n);
        n_cmp++;
        if (n != 9401) begin
            n_bad++;
            $display("FAIL default_period: cycles from t=599 to next shot %0d, required 9401", n);
        end
    endtask

    task automatic test_update();
        int n;
        skip(100);
        n_cmp++;
        if (busy_upd !== 1'b0) begin
            n_bad++;
            $display("FAIL upd_idle t=100: busy_upd=%b, required 0", busy_upd);
        end
        per = 32'd500;
        rxd = 1'b1;
        next_cycle();
        rxd = 1'b0;
        n_cmp++;
        if (busy_upd !== 1'b1) begin
            n_bad++;
            $display("FAIL upd_pend t=101: busy_upd=%b, required 1", busy_upd);
        end
        skip(9898);
        n_cmp++;
        if (busy_upd !== 1'b1 || sync !== 1'b0) begin
            n_bad++;
            $display("FAIL upd_hold t=9999: busy_upd=%b sync=%b, required 1 0", busy_upd, sync);
        end
        next_cycle();
        n_cmp++;
        if (busy_upd !== 1'b0 || sync !== 1'b1) begin
            n_bad++;
            $display("FAIL upd_apply t=0: busy_upd=%b sync=%b, required 0 1", busy_upd, sync);
        end
        count_to_sync_rise(2000, n);
        n_cmp++;
        if (n != 500) begin
            n_bad++;
            $display("FAIL upd_period: got %0d, required 500", n);
        end
    endtask

    task automatic test_cpmg();
        logic exp_p, exp_i;
        set_inputs(32'd200, 16'd10, 16'd20, 16'd5, 1'b1, 8'd3);
        commit("cpmg");
        for (int t = 0; t < 200; t++) begin
            if (t > 0) next_cycle();
            exp_p = (t < 10) || (t >= 30 && t < 35) || (t >= 75 && t < 80) ||
                    (t >= 120 && t < 125) || (t >= 165 && t < 170);
            exp_i = (t < 13) || (t >= 30 && t < 38) || (t >= 75 && t < 83) ||
                    (t >= 120 && t < 128) || (t >= 165 && t < 173);
            n_cmp++;
            if (pulse !== exp_p) begin
                n_bad++;
                $display("FAIL cpmg_pulse t=%0d: got %b, required %b", t, pulse, exp_p);
            end
            n_cmp++;
            if (inhib !== exp_i) begin
                n_bad++;
                $display("FAIL cpmg_inhib t=%0d: got %b, required %b", t, inhib, exp_i);
            end
            if (t == 40) begin
                n_cmp++;
                if (phase_dbg !== PH_GAP) begin
                    n_bad++;
                    $display("FAIL cpmg_phase t=40: got %0d, required %0d", phase_dbg, PH_GAP);
                end
            end
        end
        next_cycle();
        n_cmp++;
        if (sync !== 1'b1 || pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL cpmg_wrap t=200: sync=%b pulse=%b, required 1 1", sync, pulse);
        end
    endtask

    task automatic test_boundaries();
        logic exp_p;
        p1wid = 16'd0;
        commit("p1zero");
        n_cmp++;
        if (phase_dbg !== PH_DEL) begin
            n_bad++;
            $display("FAIL p1zero_phase t=0: got %0d, required %0d", phase_dbg, PH_DEL);
        end
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) next_cycle();
            exp_p = (t >= 20 && t < 25);
            n_cmp++;
            if (pulse !== exp_p) begin
                n_bad++;
                $display("FAIL p1zero_pulse t=%0d: got %b, required %b", t, pulse, exp_p);
            end
        end
        del = 16'd0;
        commit("delzero");
        for (int t = 0; t <= 200; t++) begin
            if (t > 0) next_cycle();
            n_cmp++;
            if (pulse !== 1'b1 || inhib !== 1'b1) begin
                n_bad++;
                $display("FAIL delzero_cont t=%0d: pulse=%b inhib=%b, required 1 1", t, pulse, inhib);
            end
        end
        n_cmp++;
        if (sync !== 1'b1) begin
            n_bad++;
            $display("FAIL delzero_wrap t=200: sync=%b, required 1", sync);
        end
    endtask

    task automatic test_bl_off();
        set_inputs(DEF_PER, DEF_P1W, DEF_DEL, DEF_P2W, 1'b0, DEF_PBL);
        bl = 1'b0;
        commit("bl_off");
        check_default_window("bl_off", 1'b0);
        bl = 1'b1;
    endtask

    task automatic test_mid_reset();
        wait_sync_rise("pre_reset_shot", 20000);
        skip(250);
        n_cmp++;
        if (pulse !== 1'b1 || inhib !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_before t=250: pulse=%b inhib=%b, required 1 1", pulse, inhib);
        end
        // Inputs differ from the defaults, so the restart must come from reset.
        set_inputs(32'd300, 16'd7, 16'd9, 16'd11, 1'b1, 8'd2);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pulse, inhib, sync, busy_upd} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_drop: got %b%b%b%b, required 0000", pulse, inhib, sync, busy_upd);
        end
        skip(2);
        rst_n = 1'b1;
        wait_sync_rise("post_reset_shot", 5);
        check_default_window("post_reset", 1'b1);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_update();
        test_cpmg();
        test_boundaries();
        test_bl_off();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Consumes the register set produced by the UART pulse-control block and generates the per-shot RF gate, receiver-inhibit and scope-sync waveforms on the 201 MHz fabric clock (4.975 ns/cycle).
- Supports a single echo (pi/2, delay, pi) and a CPMG pi-pulse train.
- Parameters are double-buffered so that a UART update never corrupts a shot in progress.

Parameters:
- DEF_PER, 10000, period loaded by reset (cycles)
- DEF_P1W, 40, pulse-1 width loaded by reset
- DEF_DEL, 150, delay loaded by reset
- DEF_P2W, 200, pulse-2 width loaded by reset
- DEF_PBL, 100, inhibit tail loaded by reset
- SYNC_W, 4, sync pulse width in cycles (must be at least 1)

Ports:
- clk  in  1  fabric clock
- rst_n  in  1  asynchronous active-low reset
- per  in  32  shot period in cycles
- p1wid  in  16  pulse-1 width
- del  in  16  pulse-1-end to pulse-2-start delay
- p2wid  in  16  pulse-2 width
- cp  in  1  1 = CPMG train, 0 = single echo
- p_bl  in  8  inhibit tail after each pulse
- bl  in  1  1 = pulses enabled, 0 = pulse output suppressed
- rxd  in  1  high while the control block is committing new values
- pulse  out  1  RF switch gate
- inhib  out  1  receiver blanking
- sync  out  1  shot-start marker
- busy_upd  out  1  an update is pending and not yet applied

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Shadow registers load the DEF_* values and cp=0.
  - Period counter t=0; phase=PH_P1; pend=0.
  - All outputs 0.
- Period start:
  - The first period starts on the first clk edge after rst_n rises.
  - t counts 0..per_s-1 and then wraps to 0.
  - Shadow per values below 2 are treated as 2.
- Update capture:
  - A rising edge of rxd sets pend.
  - On the wrap cycle (t==per_s-1) with pend=1, the shadows copy all input ports and pend clears.
  - An rxd rise on the wrap cycle itself sets pend and is applied at the next wrap.
  - busy_upd = pend.
- Phase FSM, driven by a 17-bit phase counter pc that resets to 0 on every phase change:
  - PH_P1: lasts p1wid_s cycles; skipped if p1wid_s=0.
  - PH_DEL: lasts del_s cycles; skipped if 0.
  - PH_P2: lasts p2wid_s cycles; skipped if 0. On exit, goes to PH_GAP if cp_s=1, otherwise PH_TAIL.
  - PH_GAP: lasts 2*del_s cycles (17-bit), then returns to PH_P2. If del_s=0, PH_P2 repeats back-to-back (pulse stays high).
  - PH_TAIL: holds until wrap.
  - Wrap forces phase to PH_P1 (or the first non-skipped phase), regardless of the current phase.
  - The CPMG train is truncated by the period end; a partially completed pulse is cut at the wrap.
- Outputs (registered, cycle-exact):
  - The value in cycle t reflects the phase in cycle t.
  - pulse = bl & (phase==PH_P1 or PH_P2). bl is sampled live, not shadowed.
  - sync = 1 for t < SYNC_W, independent of bl.
  - inhib = 1 while the ungated pulse condition holds, and for p_bl_s cycles after each falling edge of it, via an 8-bit down-counter that reloads on every fall. p_bl_s=0 gives inhib == ungated pulse.
  - inhib is asserted even when bl=0, so the receiver is protected identically.
- Sizing rule: if p1wid_s + del_s + p2wid_s ≥ per_s, the shot is clipped at the wrap. No error flag is raised.
- Mid-shot reset: immediate zero of all outputs; restarts from DEF_* values.

Decomposition:
- Shared package pulse_pkg:
  - phase enum (PH_P1, PH_DEL, PH_P2, PH_GAP, PH_TAIL)
  - cycle-time constant (4.975 ns) for the testbench
  - DEF_* values, shared with the control block so both reset to identical timings
- One natural sub-module: inhibit_stretch, the 8-bit falling-edge tail stretcher.

Test Plan:
- Reset release, defaults:
  - pulse high t=0..39, low 40..189, high 190..389.
  - inhib high through t=489.
  - sync high t=0..3; period 10000.
- Commit per=500 via rxd pulse at t=100:
  - Current shot still lasts 10000.
  - Next shot lasts 500.
  - busy_upd high from t=101 until the wrap.
- cp=1, p1wid=10, del=20, p2wid=5, per=200:
  - pulse at t=[0,10), [30,35), [75,80), [120,125), [165,170).
  - No pulse at or after t=200.
- Boundaries: set p1wid=0 → first pulse starts t=del. Then set del=0, cp=1 → pulse stays continuously high from t=0 to the wrap.
- bl=0 with defaults:
  - pulse never asserts.
  - inhib and sync are unchanged from the bl=1 case.
- Reset asserted at t=250 (mid pulse 2): outputs drop in the same cycle; after release, a shot starts with default timings.
